store_drain_buffer: RTL and testbench
=====================================

// Module: store_drain_buffer
// PURPOSE
//  Store-side partner of the writeback select: takes SB/SH/SW requests from the
//  execute stage, aligns them to byte lanes and queues them in a small FIFO.
//  Drains the queue to data memory over a req/ack handshake. Sits between the
//  core's store path and data memory, so the core never stalls on a slow store.
// PARAMETERS
//  DEPTH  4  FIFO entries (power of two, >=2); excludes the in-flight entry
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  st_valid   in   1   store request valid
//  st_ready   out  1   buffer can accept; equals (count < DEPTH)
//  st_addr    in   32  byte address from the ALU
//  st_data    in   32  rs2 data
//  st_funct3  in   3   000=SB, 001=SH, 010=SW; anything else is illegal
//  mem_req    out  1   memory write request
//  mem_addr   out  32  word address {addr[31:2],2'b00}
//  mem_wdata  out  32  lane-replicated write data
//  mem_wstrb  out  4   byte enables
//  mem_ack    in   1   memory accepted the current request
//  misalign   out  1   one-cycle pulse: store was misaligned or illegal
//  count      out  $clog2(DEPTH+1)  FIFO occupancy
//  drained    out  1   FIFO empty and nothing in flight (fence condition)
//  ld_addr    in   32  load address to check (STORE_FWD_CHK_EN only)
//  ld_hazard  out  1   pending store overlaps ld_addr word
// BEHAVIOUR
//  - Reset: FIFO empty; count=0; state IDLE; mem_req=0; mem_addr, mem_wdata and
//    mem_wstrb =0; misalign=0; drained=1; ld_hazard=0. Reset is asynchronous and
//    drops mem_req immediately, including mid-transaction. An unacked write is lost.
//  - Accept: on st_valid & st_ready, the store is consumed in that cycle.
//  - Alignment:
//      SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<a[1:0].
//      SH: wdata={2{d[15:0]}}, wstrb=4'b0011<<a[1:0].
//      SW: wdata=d, wstrb=4'b1111.
//  - Misaligned (SH with a[0]=1, SW with a[1:0]!=0) or illegal funct3: the store
//    is consumed but not enqueued. misalign is high in the next cycle only.
//  - The push is registered: the entry is visible in count the cycle after acceptance.
//  - Push at full is refused even if a pop occurs in the same cycle.
//  - A simultaneous push and pop at other occupancies leaves count unchanged.
//  - FIFO pointers wrap modulo DEPTH. Entries are drained in strict FIFO order.
//  - Drain FSM:
//      IDLE: if FIFO not empty, register the head into mem_*, pop it, set
//        mem_req=1 and go to BUSY.
//      BUSY: hold mem_req, mem_addr, mem_wdata and mem_wstrb stable until
//        mem_ack. On ack, if the FIFO is not empty, load and pop the next head
//        and stay in BUSY (back-to-back, no bubble). Otherwise set mem_req=0 and
//        go to IDLE.
//  - mem_ack outside BUSY is ignored.
//  - Latency: an accepted store in cycle N gives mem_req=1 in cycle N+2 when idle.
//  - drained = (count==0) & (state==IDLE).
// CONFIGURATION
//  - STORE_FWD_CHK_EN defined: ld_hazard is combinational. It is 1 when
//    ld_addr[31:2] matches the word address of any valid FIFO entry or of the
//    in-flight BUSY entry. The core stalls the load while it is 1.
//  - STORE_FWD_CHK_EN undefined: ld_hazard is tied to 0 and ld_addr is unused.
//    The core must fence using drained.
// TESTING
//  1. SB a=0x103, d=0xAB, immediate ack -> mem_addr=0x100, wdata=0xABABABAB,
//     wstrb=4'b1000, mem_req 1 cycle.
//  2. SH a=0x102, d=0x1234 -> wdata=0x12341234, wstrb=4'b1100. Then SH a=0x101
//     -> misalign pulse, count stays 0, no mem_req.
//  3. mem_ack held 0, 6 SW issued -> 1 in flight + 4 queued, st_ready=0 after
//     the 5th. Then release ack -> 5 writes in issue order, count 4->0.
//  4. mem_ack=1 continuously, 3 consecutive SW -> mem_req high 3 consecutive
//     cycles, then drained=1.
//  5. Assert rst while BUSY with count=2 -> mem_req=0 same cycle, count=0,
//     drained=1, no further writes.
//  6. (STORE_FWD_CHK_EN) SW a=0x200 pending, ld_addr=0x202 -> ld_hazard=1.
//     ld_addr=0x204 -> 0. After ack drains it -> 0.

Source files
------------

// File: rtl/store_drain_buffer.sv
// Store drain buffer: aligns SB/SH/SW stores to byte lanes, queues them and drains to memory.
// Optional load-overlap check is compiled in with `define STORE_FWD_CHK_EN.
module store_drain_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_st_valid,
  output logic                       o_st_ready,
  input  logic [31:0]                i_st_addr,
  input  logic [31:0]                i_st_data,
  input  logic [2:0]                 i_st_funct3,
  output logic                       o_mem_req,
  output logic [31:0]                o_mem_addr,
  output logic [31:0]                o_mem_wdata,
  output logic [3:0]                 o_mem_wstrb,
  input  logic                       i_mem_ack,
  output logic                       o_misalign,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_drained,
  input  logic [31:0]                i_ld_addr,
  output logic                       o_ld_hazard
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  function automatic logic is_bad(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  is_bad = 1'b0;
      3'b001:  is_bad = a[0];
      3'b010:  is_bad = (a != 2'b00);
      default: is_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   lane_data = {4{d[7:0]}};
      2'b01:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  function automatic logic [3:0] lane_strb(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   lane_strb = 4'b0001 << a;
      2'b01:   lane_strb = 4'b0011 << a;
      default: lane_strb = 4'b1111;
    endcase
  endfunction

  logic [29:0]   r_fifo_addr  [DEPTH];
  logic [31:0]   r_fifo_wdata [DEPTH];
  logic [3:0]    r_fifo_wstrb [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_misalign_p1;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;
  logic          w_bad;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;

  assign o_st_ready = (r_count < FULL);
  assign w_empty    = (r_count == '0);
  assign w_accept   = i_st_valid & o_st_ready;
  assign w_bad      = is_bad(i_st_funct3, i_st_addr[1:0]);
  assign w_push     = w_accept & ~w_bad;
  assign o_count    = r_count;
  assign o_misalign = r_misalign_p1;
  assign o_drained  = w_empty & (r_state == S_IDLE);

  // Accept stage: aligned entry lands in the FIFO at the accepting edge
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr]  <= i_st_addr[31:2];
      r_fifo_wdata[r_wr_ptr] <= lane_data(i_st_funct3[1:0], i_st_data);
      r_fifo_wstrb[r_wr_ptr] <= lane_strb(i_st_funct3[1:0], i_st_addr[1:0]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_misalign_p1 <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      r_misalign_p1 <= w_accept & w_bad;
    end
  end

  // Drain stage: the head moves into the memory request registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (i_mem_ack) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
    end else if (w_pop) begin
      o_mem_req   <= 1'b1;
      o_mem_addr  <= {r_fifo_addr[r_rd_ptr], 2'b00};
      o_mem_wdata <= r_fifo_wdata[r_rd_ptr];
      o_mem_wstrb <= r_fifo_wstrb[r_rd_ptr];
    end else if ((r_state == S_BUSY) && i_mem_ack) begin
      o_mem_req   <= 1'b0;
    end
  end

`ifdef STORE_FWD_CHK_EN
  // Occupied slots are the count entries starting at the read pointer
  always_comb begin
    o_ld_hazard = (r_state == S_BUSY) && (o_mem_addr[31:2] == i_ld_addr[31:2]);
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_fifo_addr[r_rd_ptr + PW'(i)] == i_ld_addr[31:2]))
        o_ld_hazard = 1'b1;
    end
  end
`else
  logic w_unused_ld;
  assign w_unused_ld = ^i_ld_addr;
  assign o_ld_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_store_drain_buffer.sv
// Self-checking bench for store_drain_buffer: directed scenarios plus random traffic
// against a queue-based reference of the buffer and its single in-flight write.
module tb_store_drain_buffer;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [31:0]   st_addr = '0;
  logic [31:0]   st_data = '0;
  logic [2:0]    st_funct3 = '0;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ack = 1'b0;
  logic          misalign;
  logic [CW-1:0] count;
  logic          drained;
  logic [31:0]   ld_addr = '0;
  logic          ld_hazard;

  store_drain_buffer #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_st_valid(st_valid), .o_st_ready(st_ready),
    .i_st_addr(st_addr), .i_st_data(st_data), .i_st_funct3(st_funct3),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_wstrb(mem_wstrb), .i_mem_ack(mem_ack),
    .o_misalign(misalign), .o_count(count), .o_drained(drained),
    .i_ld_addr(ld_addr), .o_ld_hazard(ld_hazard)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t mq[$];
  logic m_busy = 1'b0;
  ent_t m_cur  = '0;
  logic m_mis  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_hazard();
    logic h = 1'b0;
`ifdef STORE_FWD_CHK_EN
    if (m_busy && (m_cur.addr[31:2] == ld_addr[31:2])) h = 1'b1;
    foreach (mq[i]) if (mq[i].addr[31:2] == ld_addr[31:2]) h = 1'b1;
`endif
    return h;
  endfunction

  // Wait for the falling edge and compare every output to the reference
  task automatic tick();
    @(negedge clk);
    chk("st_ready",  32'(st_ready),  32'(mq.size() < DEPTH));
    chk("mem_req",   32'(mem_req),   32'(m_busy));
    chk("mem_addr",  mem_addr,       m_cur.addr);
    chk("mem_wdata", mem_wdata,      m_cur.wdata);
    chk("mem_wstrb", 32'(mem_wstrb), 32'(m_cur.strb));
    chk("misalign",  32'(misalign),  32'(m_mis));
    chk("count",     32'(count),     32'(mq.size()));
    chk("drained",   32'(drained),   32'((mq.size() == 0) && !m_busy));
    chk("ld_hazard", 32'(ld_hazard), 32'(exp_hazard()));
  endtask

  // Drive one cycle of inputs and advance the reference across the coming edge
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input logic ack);
    logic acc, bad;
    ent_t e;
    st_valid = v; st_addr = a; st_data = d; st_funct3 = f3; mem_ack = ack;
    bad = !((f3 == 3'd0) || ((f3 == 3'd1) && !a[0]) || ((f3 == 3'd2) && (a[1:0] == 2'd0)));
    acc = v && (mq.size() < DEPTH);
    if (!m_busy) begin
      if (mq.size() > 0) begin m_cur = mq.pop_front(); m_busy = 1'b1; end
    end else if (ack) begin
      if (mq.size() > 0) m_cur = mq.pop_front();
      else               m_busy = 1'b0;
    end
    if (acc && !bad) begin
      e.addr = a & 32'hFFFF_FFFC;
      case (f3)
        3'd0: begin e.wdata = {24'h0, d[7:0]} * 32'h0101_0101; e.strb = 4'(4'd1 << a[1:0]); end
        3'd1: begin e.wdata = {16'h0, d[15:0]} * 32'h0001_0001; e.strb = 4'(4'd3 << a[1:0]); end
        default: begin e.wdata = d; e.strb = 4'hF; end
      endcase
      mq.push_back(e);
    end
    m_mis = acc && bad;
  endtask

  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input logic ack);
    tick();
    drive(v, a, d, f3, ack);
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 3'd0, ack);
  endtask

  task automatic model_clear();
    mq.delete();
    m_busy = 1'b0;
    m_cur  = '0;
    m_mis  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_req",     32'(mem_req),   32'd0);
    chk("rst_count",   32'(count),     32'd0);
    chk("rst_drained", 32'(drained),   32'd1);
    chk("rst_addr",    mem_addr,       32'd0);
    chk("rst_wdata",   mem_wdata,      32'd0);
    chk("rst_wstrb",   32'(mem_wstrb), 32'd0);
    chk("rst_mis",     32'(misalign),  32'd0);
    chk("rst_hazard",  32'(ld_hazard), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);

    // SB to the top byte lane, memory acks at once
    cyc(1'b1, 32'h103, 32'h0000_00AB, 3'd0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    tick();
    chk("t1_req",   32'(mem_req),   32'd1);
    chk("t1_addr",  mem_addr,       32'h100);
    chk("t1_wdata", mem_wdata,      32'hABAB_ABAB);
    chk("t1_wstrb", 32'(mem_wstrb), 32'h8);
    drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    tick();
    chk("t1_req_drop", 32'(mem_req), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

    // Upper-half SH, then a misaligned SH
    cyc(1'b1, 32'h102, 32'h0000_1234, 3'd1, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    tick();
    chk("t2_wdata", mem_wdata,      32'h1234_1234);
    chk("t2_wstrb", 32'(mem_wstrb), 32'hC);
    drive(1'b1, 32'h101, 32'h0000_5678, 3'd1, 1'b1);
    tick();
    chk("t2_mis",   32'(misalign), 32'd1);
    chk("t2_count", 32'(count),    32'd0);
    drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    tick();
    chk("t2_mis_drop", 32'(misalign), 32'd0);
    chk("t2_no_req",   32'(mem_req),  32'd0);
    drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

    // Stalled memory fills the buffer; then it drains in order
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h300 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 3'd2, 1'b0);
    tick();
    chk("t3_full_cnt",   32'(count),    32'd4);
    chk("t3_full_ready", 32'(st_ready), 32'd0);
    chk("t3_inflight",   mem_addr,      32'h300);
    drive(1'b1, 32'h314, 32'hC0DE_0005, 3'd2, 1'b0);
    cyc(1'b1, 32'h314, 32'hC0DE_0005, 3'd2, 1'b0);
    idle(12, 1'b1);

    // Continuous ack, three back-to-back words
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h400 + 32'(4*i), $urandom, 3'd2, 1'b1);
    idle(6, 1'b1);

    // Reset while busy with two entries queued
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h500 + 32'(4*i), $urandom, 3'd2, 1'b0);
    tick();
    chk("t5_pre_cnt", 32'(count), 32'd2);
    drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_req",     32'(mem_req), 32'd0);
    chk("t5_count",   32'(count),   32'd0);
    chk("t5_drained", 32'(drained), 32'd1);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    idle(4, 1'b1);

`ifdef STORE_FWD_CHK_EN
    cyc(1'b1, 32'h200, 32'h1111_2222, 3'd2, 1'b0);
    idle(2, 1'b0);
    ld_addr = 32'h202;
    tick();
    chk("t6_hit", 32'(ld_hazard), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    ld_addr = 32'h204;
    tick();
    chk("t6_miss", 32'(ld_hazard), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    ld_addr = 32'h200;
    idle(3, 1'b1);
    tick();
    chk("t6_done", 32'(ld_hazard), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
`endif

    // Random traffic over a small address window so overlaps occur
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] f3;
      f3 = (($urandom % 8) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      ld_addr = 32'h200 + 32'($urandom_range(0, 15));
      cyc(($urandom % 3) != 0, 32'h200 + 32'($urandom_range(0, 15)), $urandom, f3,
          ($urandom % 3) == 0);
    end
    idle(20, 1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
